// File: rtl/o_buf_controller.sv
// Linebuffer read-out controller: fetches 32-bit words from a double-banked
// linebuffer and streams them as 8-bit pixels with SOL/EOL/SOF framing.
module o_buf_controller #(
    parameter int unsigned LINE_PIXELS = 640
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        line_valid,
    input  logic        frame_valid,
    output logic        re,
    output logic [31:0] addr,
    input  logic [31:0] i_data,
    output logic [7:0]  o_pixel,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        o_sol,
    output logic        o_eol,
    output logic        o_sof,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned LINE_WORDS = LINE_PIXELS / 4;
    localparam int unsigned PIX_W      = $clog2(LINE_PIXELS);
    localparam int unsigned WCNT_W     = $clog2(LINE_WORDS + 1);
    localparam int unsigned LAST_PIX   = LINE_PIXELS - 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state_q, state_n;
    logic                bank_q, bank_n;
    logic                base_q, base_n;
    logic [WCNT_W-1:0]   rd_cnt_q, rd_cnt_n;
    logic                re_q, re_n;
    logic [31:0]         addr_q, addr_n;
    logic                rd_pend_q, rd_pend_n;
    logic [31:0]         cur_q, cur_n;
    logic                cur_vld_q, cur_vld_n;
    logic [31:0]         pf_q, pf_n;
    logic                pf_vld_q, pf_vld_n;
    logic [PIX_W-1:0]    pix_q, pix_n;
    logic                line_sof_q, line_sof_n;
    logic                sof_pend_q, sof_pend_n;
    logic                overflow_q, overflow_n;
    logic                busy_q, busy_n;

    logic [31:0]         cur_src;
    logic [7:0]          pix_byte;
    logic                avail;
    logic                hs;
    logic                last_hs;
    logic                word_done;
    logic                accept;

    // A word arriving from the linebuffer is shown directly so the first
    // pixel appears in the same cycle its read data returns.
    always_comb begin
        cur_src = cur_vld_q ? cur_q : i_data;
        case (pix_q[1:0])
            2'd0:    pix_byte = cur_src[7:0];
            2'd1:    pix_byte = cur_src[15:8];
            2'd2:    pix_byte = cur_src[23:16];
            default: pix_byte = cur_src[31:24];
        endcase
    end

    assign avail     = cur_vld_q | rd_pend_q;
    assign hs        = avail & o_ready;
    assign last_hs   = hs & (pix_q == PIX_W'(LAST_PIX));
    assign word_done = hs & (pix_q[1:0] == 2'd3);

    assign o_valid  = avail;
    assign o_pixel  = avail ? pix_byte : 8'd0;
    assign o_sol    = avail & (pix_q == '0);
    assign o_eol    = avail & (pix_q == PIX_W'(LAST_PIX));
    assign o_sof    = avail & (pix_q == '0) & line_sof_q;
    assign re       = re_q;
    assign addr     = addr_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q    <= IDLE;
            bank_q     <= 1'b0;
            base_q     <= 1'b0;
            rd_cnt_q   <= '0;
            re_q       <= 1'b0;
            addr_q     <= 32'd0;
            rd_pend_q  <= 1'b0;
            cur_q      <= 32'd0;
            cur_vld_q  <= 1'b0;
            pf_q       <= 32'd0;
            pf_vld_q   <= 1'b0;
            pix_q      <= '0;
            line_sof_q <= 1'b0;
            sof_pend_q <= 1'b1;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            bank_q     <= bank_n;
            base_q     <= base_n;
            rd_cnt_q   <= rd_cnt_n;
            re_q       <= re_n;
            addr_q     <= addr_n;
            rd_pend_q  <= rd_pend_n;
            cur_q      <= cur_n;
            cur_vld_q  <= cur_vld_n;
            pf_q       <= pf_n;
            pf_vld_q   <= pf_vld_n;
            pix_q      <= pix_n;
            line_sof_q <= line_sof_n;
            sof_pend_q <= sof_pend_n;
            overflow_q <= overflow_n;
            busy_q     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        bank_n     = bank_q;
        base_n     = base_q;
        rd_cnt_n   = rd_cnt_q;
        re_n       = 1'b0;
        addr_n     = addr_q;
        rd_pend_n  = re_q;
        cur_n      = cur_q;
        cur_vld_n  = cur_vld_q;
        pf_n       = pf_q;
        pf_vld_n   = pf_vld_q;
        pix_n      = pix_q;
        line_sof_n = line_sof_q;
        sof_pend_n = sof_pend_q;
        overflow_n = overflow_q;
        accept     = 1'b0;

        // A new line may only start from idle or on the final pixel handshake.
        case (state_q)
            IDLE: begin
                if (line_valid) begin
                    accept  = 1'b1;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (last_hs && line_valid) begin
                    accept = 1'b1;
                end else if (last_hs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (line_valid && !accept) begin
            overflow_n = 1'b1;
        end

        if (accept) begin
            line_sof_n = sof_pend_q | frame_valid;
            sof_pend_n = 1'b0;
        end else if (frame_valid) begin
            sof_pend_n = 1'b1;
        end

        if (hs) begin
            pix_n = last_hs ? '0 : pix_q + PIX_W'(1);
        end

        // Word pipeline: current word feeds pixels, prefetch holds the next one.
        if (cur_vld_q) begin
            if (word_done) begin
                if (pf_vld_q) begin
                    cur_n    = pf_q;
                    pf_vld_n = rd_pend_q;
                    if (rd_pend_q) begin
                        pf_n = i_data;
                    end
                end else if (rd_pend_q) begin
                    cur_n = i_data;
                end else begin
                    cur_vld_n = 1'b0;
                end
            end else if (rd_pend_q) begin
                pf_n     = i_data;
                pf_vld_n = 1'b1;
            end
        end else if (rd_pend_q) begin
            cur_n     = i_data;
            cur_vld_n = 1'b1;
        end

        if (accept) begin
            bank_n   = ~bank_q;
            base_n   = bank_q;
            rd_cnt_n = '0;
            pix_n    = '0;
        end

        // One outstanding read at a time, only into an empty prefetch slot.
        if ((state_n == STREAM) && (rd_cnt_n < WCNT_W'(LINE_WORDS)) &&
            !re_q && !pf_vld_n) begin
            re_n     = 1'b1;
            addr_n   = (base_n ? 32'(LINE_WORDS) : 32'd0) + 32'(rd_cnt_n);
            rd_cnt_n = rd_cnt_n + WCNT_W'(1);
        end
    end

    assign busy_n = (state_n == STREAM);

endmodule

// File: tb/tb_o_buf_controller.sv
// Bench for o_buf_controller: directed scenarios plus randomized traffic,
// all checked against a line-level pixel/address queue model.
module tb_o_buf_controller;

    localparam int unsigned LP = 8;
    localparam int unsigned W  = LP / 4;

    typedef struct packed {
        logic [7:0] pix;
        logic       sol;
        logic       eol;
        logic       sof;
    } pix_t;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        line_valid = 1'b0;
    logic        frame_valid = 1'b0;
    logic        re;
    logic [31:0] addr;
    logic [31:0] i_data = 32'd0;
    logic [7:0]  o_pixel;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic        o_sol, o_eol, o_sof, busy, overflow;

    o_buf_controller #(.LINE_PIXELS(LP)) dut (
        .pclk(pclk), .reset(reset), .line_valid(line_valid), .frame_valid(frame_valid),
        .re(re), .addr(addr), .i_data(i_data), .o_pixel(o_pixel), .o_valid(o_valid),
        .o_ready(o_ready), .o_sol(o_sol), .o_eol(o_eol), .o_sof(o_sof),
        .busy(busy), .overflow(overflow)
    );

    always #5 pclk = ~pclk;

    logic [31:0] mem [0:2*W-1];

    // Linebuffer: read data appears the cycle after re.
    always @(posedge pclk) begin
        if (re) begin
            if (int'(addr) < int'(2 * W)) i_data <= mem[int'(addr)];
            else                          i_data <= 32'hDEAD_BEEF;
        end
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    pix_t        exp_q[$];
    logic [31:0] exp_addr[$];
    logic        m_busy, m_bank, m_sof_pend, m_ovf;
    int          lat;
    logic        after_rst;
    logic        refill_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_addr.delete();
        m_busy = 1'b0; m_bank = 1'b0; m_sof_pend = 1'b1; m_ovf = 1'b0;
        lat = 3; after_rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, check current outputs, advance model.
    task automatic step(input logic lv, input logic fv, input logic rdy, input logic rs);
        pix_t e;
        logic hs, fin, acc, sofl;
        int   base;
        line_valid = lv; frame_valid = fv; o_ready = rdy; reset = rs;

        if (after_rst) begin
            chk("rst_addr", addr, 32'd0);
            chk("rst_pixel", 32'(o_pixel), 32'd0);
            chk("rst_flags", {29'd0, o_sol, o_eol, o_sof}, 32'd0);
            chk("rst_re", 32'(re), 32'd0);
            after_rst = 1'b0;
        end
        if (lat == 1) chk("re_latency", 32'(re), 32'd1);
        if (re) begin
            if (exp_addr.size() == 0) chk("re_unexpected", 32'(re), 32'd0);
            else                      chk("addr", addr, exp_addr.pop_front());
        end
        chk("o_valid", 32'(o_valid), 32'((exp_q.size() > 0) && (lat >= 2)));
        if (o_valid && exp_q.size() > 0) begin
            chk("pixel", 32'(o_pixel), 32'(exp_q[0].pix));
            chk("sol_eol_sof", {29'd0, o_sol, o_eol, o_sof},
                {29'd0, exp_q[0].sol, exp_q[0].eol, exp_q[0].sof});
        end
        chk("busy", 32'(busy), 32'(m_busy));
        chk("overflow", 32'(overflow), 32'(m_ovf));

        if (rs) begin
            model_reset();
        end else begin
            hs  = o_valid && rdy && (exp_q.size() > 0);
            fin = 1'b0;
            if (hs) begin
                e   = exp_q.pop_front();
                fin = e.eol;
            end
            acc = lv && (!m_busy || fin);
            if (lv && !acc) m_ovf = 1'b1;
            if (acc) begin
                sofl       = m_sof_pend | fv;
                m_sof_pend = 1'b0;
                base       = m_bank ? int'(W) : 0;
                for (int w = 0; w < int'(W); w++) begin
                    if (refill_en) mem[base + w] = $urandom;
                    exp_addr.push_back(32'(base + w));
                    for (int b = 0; b < 4; b++) begin
                        e.pix = mem[base + w][8*b +: 8];
                        e.sol = (w == 0) && (b == 0);
                        e.eol = (w == int'(W) - 1) && (b == 3);
                        e.sof = e.sol && sofl;
                        exp_q.push_back(e);
                    end
                end
                m_bank = ~m_bank;
                m_busy = 1'b1;
                lat    = 1;
            end else begin
                if (fv) m_sof_pend = 1'b1;
                if (fin) m_busy = 1'b0;
                if (lat < 3) lat++;
            end
        end
        @(negedge pclk);
    endtask

    initial begin
        logic rdy, lv, fv, rs;
        refill_en = 1'b0;
        mem[0] = 32'h0302_0100; mem[1] = 32'h0706_0504;
        mem[2] = 32'h1716_1514; mem[3] = 32'h1B1A_1918;
        reset = 1'b1;
        repeat (3) @(negedge pclk);
        model_reset();

        // Basic line, then a backpressured line from the second bank.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, (i % 2) == 0, 1'b0);

        // Frame boundary before the third line (back at bank 0).
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Overflow at pixel 3, then back-to-back start on the EOL handshake.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a line, then a fresh line.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b1, 1'b0);

        refill_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rdy = ($urandom % 4) != 0;
            if (o_valid && rdy && exp_q.size() == 1) lv = ($urandom % 2) == 0;
            else lv = ($urandom % 100) < (m_busy ? 3 : 8);
            fv = ($urandom % 30) == 0;
            rs = ($urandom % 600) == 0;
            step(lv, fv, rdy, rs);
        end
        repeat (30) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain_pixels", 32'(exp_q.size()), 32'd0);
        chk("drain_reads", 32'(exp_addr.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
